// File: rtl/ddr4_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_cmd_issue
// Brief    : DDR4 command issue stage. Buffers abstract scheduler requests in
//            a small FIFO and drives registered DDR4 command/address pins with
//            per-rank chip select, broadcast, 1T/2T timing and CA parity.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_cmd_issue #(
  parameter int RANKS     = 2,
  parameter int RANK_BITS = (RANKS > 1) ? $clog2(RANKS) : 1,
  parameter int DEPTH     = 4,
  parameter int COL_BITS  = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_cmd,
  input  logic [RANK_BITS-1:0]   req_rank,
  input  logic                   req_all,
  input  logic [1:0]             req_bg,
  input  logic [1:0]             req_ba,
  input  logic [17:0]            req_addr,
  input  logic                   req_ap,
  input  logic                   mode_2t,
  input  logic                   par_en,
  output logic [RANKS-1:0]       CS_n,
  output logic                   ACT_n,
  output logic                   RAS_n_A16,
  output logic                   CAS_n_A15,
  output logic                   WE_n_A14,
  output logic                   A17,
  output logic [1:0]             BG,
  output logic [1:0]             BA,
  output logic [13:0]            ADDR,
  output logic                   PARITY,
  output logic                   cmd_issued,
  output logic                   rank_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = DEPTH[AW:0];

  localparam logic [2:0] c_CMD_DES  = 3'd0;
  localparam logic [2:0] c_CMD_ACT  = 3'd1;
  localparam logic [2:0] c_CMD_RD   = 3'd2;
  localparam logic [2:0] c_CMD_WR   = 3'd3;
  localparam logic [2:0] c_CMD_PRE  = 3'd4;
  localparam logic [2:0] c_CMD_PREA = 3'd5;
  localparam logic [2:0] c_CMD_REF  = 3'd6;
  localparam logic [2:0] c_CMD_MRS  = 3'd7;

  typedef struct packed {
    logic [2:0]           cmd;
    logic [RANK_BITS-1:0] rank;
    logic                 all;
    logic [1:0]           bg;
    logic [1:0]           ba;
    logic [17:0]          addr;
    logic                 ap;
  } entry_t;

  // r_state describes what the pins will show after the next edge; the
  // command being worked on has already been popped into r_cmd.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ASSERT = 2'd2
  } state_t;

  entry_t         r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr, r_rd_ptr;
  entry_t         r_cmd;
  logic           r_cur_2t;
  state_t         r_state, w_state_nxt;
  entry_t         w_wr_entry, w_head;
  logic           w_push, w_pop, w_empty;
  logic           w_bcast, w_rank_bad;
  logic           w_act_n, w_ras, w_cas, w_we, w_a17, w_issue, w_err;
  logic [1:0]     w_bg, w_ba;
  logic [13:0]    w_addr;
  logic [RANKS-1:0] w_cs;

  assign fifo_count = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (fifo_count == '0);
  assign req_ready  = (fifo_count != c_FULL);
  assign w_push     = req_valid && req_ready;
  assign w_wr_entry = {req_cmd, req_rank, req_all, req_bg, req_ba, req_addr, req_ap};
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  // Broadcast only applies to commands that make sense on every rank.
  assign w_bcast    = r_cmd.all && ((r_cmd.cmd == c_CMD_PREA) ||
                                    (r_cmd.cmd == c_CMD_REF)  ||
                                    (r_cmd.cmd == c_CMD_MRS));
  assign w_rank_bad = !w_bcast && (int'(r_cmd.rank) >= RANKS);

  // FIFO storage write (no reset needed, validity is held by the pointers)
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Issue FSM next-state and pop decision
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = mode_2t ? S_SETUP : S_ASSERT;
        end
      end
      S_SETUP: w_state_nxt = S_ASSERT;
      S_ASSERT: begin
        // 2T commands always get a DES gap; 1T commands issue back-to-back
        if (!r_cur_2t && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = mode_2t ? S_SETUP : S_ASSERT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, current command and the timing mode it was popped with
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cmd    <= '0;
      r_cur_2t <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_cmd    <= w_head;
        r_cur_2t <= mode_2t;
      end
    end
  end

  // Encode the next pin values; DES unless a command is in SETUP/ASSERT
  always_comb begin
    w_act_n = 1'b1;
    w_ras   = 1'b1;
    w_cas   = 1'b1;
    w_we    = 1'b1;
    w_bg    = 2'b00;
    w_ba    = 2'b00;
    w_addr  = '0;
    w_a17   = 1'b0;
    w_cs    = '1;
    w_issue = 1'b0;
    w_err   = 1'b0;
    if (r_state != S_IDLE) begin
      case (r_cmd.cmd)
        c_CMD_ACT: begin
          w_act_n = 1'b0;
          w_ras   = r_cmd.addr[16];
          w_cas   = r_cmd.addr[15];
          w_we    = r_cmd.addr[14];
          w_bg    = r_cmd.bg;
          w_ba    = r_cmd.ba;
          w_addr  = r_cmd.addr[13:0];
          w_a17   = r_cmd.addr[17];
        end
        c_CMD_RD, c_CMD_WR: begin
          w_cas  = 1'b0;
          w_we   = (r_cmd.cmd == c_CMD_RD);
          w_bg   = r_cmd.bg;
          w_ba   = r_cmd.ba;
          w_addr[COL_BITS-1:0] = r_cmd.addr[COL_BITS-1:0];
          w_addr[12] = 1'b1;
          w_addr[10] = r_cmd.ap;
        end
        c_CMD_PRE: begin
          w_ras = 1'b0;
          w_we  = 1'b0;
          w_bg  = r_cmd.bg;
          w_ba  = r_cmd.ba;
        end
        c_CMD_PREA: begin
          w_ras      = 1'b0;
          w_we       = 1'b0;
          w_addr[10] = 1'b1;
        end
        c_CMD_REF: begin
          w_ras = 1'b0;
          w_cas = 1'b0;
        end
        c_CMD_MRS: begin
          w_ras  = 1'b0;
          w_cas  = 1'b0;
          w_we   = 1'b0;
          w_bg   = r_cmd.bg;
          w_ba   = r_cmd.ba;
          w_addr = r_cmd.addr[13:0];
        end
        default: ;
      endcase
      // Chip select only in ASSERT; an out-of-range rank selects nothing
      if ((r_state == S_ASSERT) && (r_cmd.cmd != c_CMD_DES)) begin
        w_err   = w_rank_bad;
        w_issue = !w_rank_bad;
        for (int i = 0; i < RANKS; i++) begin
          w_cs[i] = !(w_bcast || (int'(r_cmd.rank) == i));
        end
      end
    end
  end

  // Registered pin outputs with parity computed over the same next values
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CS_n       <= '1;
      ACT_n      <= 1'b1;
      RAS_n_A16  <= 1'b1;
      CAS_n_A15  <= 1'b1;
      WE_n_A14   <= 1'b1;
      A17        <= 1'b0;
      BG         <= 2'b00;
      BA         <= 2'b00;
      ADDR       <= '0;
      PARITY     <= 1'b0;
      cmd_issued <= 1'b0;
      rank_err   <= 1'b0;
    end else begin
      CS_n       <= w_cs;
      ACT_n      <= w_act_n;
      RAS_n_A16  <= w_ras;
      CAS_n_A15  <= w_cas;
      WE_n_A14   <= w_we;
      A17        <= w_a17;
      BG         <= w_bg;
      BA         <= w_ba;
      ADDR       <= w_addr;
      PARITY     <= par_en & (^{w_act_n, w_ras, w_cas, w_we, w_bg, w_ba, w_addr, w_a17});
      cmd_issued <= w_issue;
      rank_err   <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_cmd_issue
// Brief    : Directed self-checking bench for ddr4_cmd_issue (RANKS=2, with a
//            2-bit rank field so an out-of-range rank can be requested).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_cmd_issue;

  localparam logic [2:0] c_ACT  = 3'd1;
  localparam logic [2:0] c_RD   = 3'd2;
  localparam logic [2:0] c_PREA = 3'd5;
  localparam logic [2:0] c_REF  = 3'd6;
  localparam logic [2:0] c_MRS  = 3'd7;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready;
  logic [2:0]  req_cmd;
  logic [1:0]  req_rank;
  logic        req_all;
  logic [1:0]  req_bg, req_ba;
  logic [17:0] req_addr;
  logic        req_ap, mode_2t, par_en;
  logic [1:0]  CS_n;
  logic        ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, A17;
  logic [1:0]  BG, BA;
  logic [13:0] ADDR;
  logic        PARITY, cmd_issued, rank_err;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  ddr4_cmd_issue #(
    .RANKS(2), .RANK_BITS(2), .DEPTH(4), .COL_BITS(10)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_rank(req_rank), .req_all(req_all),
    .req_bg(req_bg), .req_ba(req_ba), .req_addr(req_addr), .req_ap(req_ap),
    .mode_2t(mode_2t), .par_en(par_en),
    .CS_n(CS_n), .ACT_n(ACT_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15),
    .WE_n_A14(WE_n_A14), .A17(A17), .BG(BG), .BA(BA), .ADDR(ADDR),
    .PARITY(PARITY), .cmd_issued(cmd_issued), .rank_err(rank_err),
    .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic [2:0] cmd, input logic [1:0] rank, input logic all,
                         input logic [1:0] bg, input logic [1:0] ba,
                         input logic [17:0] addr, input logic ap);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_rank  = rank;
    req_all   = all;
    req_bg    = bg;
    req_ba    = ba;
    req_addr  = addr;
    req_ap    = ap;
  endtask

  task automatic push(input logic [2:0] cmd, input logic [1:0] rank, input logic all,
                      input logic [1:0] bg, input logic [1:0] ba,
                      input logic [17:0] addr, input logic ap);
    set_req(cmd, rank, all, bg, ba, addr, ap);
    tick;
    req_valid = 1'b0;
  endtask

  function automatic logic [3:0] pins();
    return {ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
  endfunction

  int exp_cnt_2t [7] = '{1, 1, 2, 3, 3, 4, 4};

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_cmd = '0; req_rank = '0; req_all = 1'b0;
    req_bg = '0; req_ba = '0; req_addr = '0; req_ap = 1'b0;
    mode_2t = 1'b0; par_en = 1'b0;
    repeat (2) tick;

    // Reset state
    check_val("rst_cs",    CS_n, 2'b11);
    check_val("rst_pins",  pins(), 4'hF);
    check_val("rst_bgba",  {BG, BA}, 4'h0);
    check_val("rst_addr",  {A17, ADDR}, 15'h0);
    check_val("rst_flags", {PARITY, cmd_issued, rank_err}, 3'b000);
    check_val("rst_cnt",   fifo_count, 3'd0);
    check_val("rst_ready", req_ready, 1'b1);
    RST = 1'b0;
    tick;

    // ACT rank1 row 0x14ABC: row[16]=1, row[15]=0, row[14]=1, row[17]=0
    push(c_ACT, 2'd1, 1'b0, 2'd2, 2'd1, 18'h14ABC, 1'b0);
    check_val("act_cnt_push", fifo_count, 3'd1);
    tick;
    check_val("act_cnt_pop", fifo_count, 3'd0);
    check_val("act_cs_early", CS_n, 2'b11);
    tick;
    check_val("act_cs",   CS_n, 2'b01);
    check_val("act_pins", pins(), 4'b0101);
    check_val("act_addr", ADDR, 14'h0ABC);
    check_val("act_a17",  A17, 1'b0);
    check_val("act_bgba", {BG, BA}, {2'd2, 2'd1});
    check_val("act_iss",  cmd_issued, 1'b1);
    check_val("act_par",  PARITY, 1'b0);
    tick;
    check_val("act_des_cs",  CS_n, 2'b11);
    check_val("act_des_iss", cmd_issued, 1'b0);
    tick;

    // Four 1T RDs back-to-back: ASSERT after edges 2..5, DES after edge 6
    for (int c = 0; c < 7; c++) begin
      if (c < 4) set_req(c_RD, 2'd0, 1'b0, 2'd1, 2'd3, 18'h003F0, 1'b1);
      else       req_valid = 1'b0;
      tick;
      if (c >= 2 && c <= 5) begin
        check_val($sformatf("rd1t_cs_%0d", c),   CS_n, 2'b10);
        check_val($sformatf("rd1t_iss_%0d", c),  cmd_issued, 1'b1);
        check_val($sformatf("rd1t_pins_%0d", c), pins(), 4'b1101);
        check_val($sformatf("rd1t_addr_%0d", c), ADDR, 14'h17F0);
      end
      if (c == 6) begin
        check_val("rd1t_des_cs",   CS_n, 2'b11);
        check_val("rd1t_des_iss",  cmd_issued, 1'b0);
        check_val("rd1t_des_pins", pins(), 4'hF);
      end
    end
    tick;

    // Broadcast REF: BG/BA/ADDR forced to zero, parity over 1,0,0,1 = 0
    par_en = 1'b1;
    push(c_REF, 2'd0, 1'b1, 2'd3, 2'd3, 18'h3FFFF, 1'b0);
    tick; tick;
    check_val("ref_cs",   CS_n, 2'b00);
    check_val("ref_pins", pins(), 4'b1001);
    check_val("ref_bgba", {BG, BA}, 4'h0);
    check_val("ref_addr", ADDR, 14'h0);
    check_val("ref_par",  PARITY, 1'b0);
    check_val("ref_iss",  cmd_issued, 1'b1);
    tick;

    // MRS rank0 BA=1 value 0x041D: 1 + 0 + 5 addr ones + 1 BA bit = odd
    push(c_MRS, 2'd0, 1'b0, 2'd0, 2'd1, 18'h0041D, 1'b0);
    tick; tick;
    check_val("mrs_cs",   CS_n, 2'b10);
    check_val("mrs_pins", pins(), 4'b1000);
    check_val("mrs_addr", ADDR, 14'h041D);
    check_val("mrs_ba",   BA, 2'd1);
    check_val("mrs_par",  PARITY, 1'b1);
    tick;

    // Broadcast PREA: A10 set, BG/BA zero; parity 1,0,1,0 + A10 = odd
    push(c_PREA, 2'd1, 1'b1, 2'd2, 2'd1, 18'h0, 1'b0);
    tick; tick;
    check_val("prea_cs",   CS_n, 2'b00);
    check_val("prea_pins", pins(), 4'b1010);
    check_val("prea_addr", ADDR, 14'h0400);
    check_val("prea_bgba", {BG, BA}, 4'h0);
    check_val("prea_par",  PARITY, 1'b1);
    tick;

    // Out-of-range rank followed by a valid ACT
    par_en = 1'b0;
    push(c_ACT, 2'd2, 1'b0, 2'd1, 2'd2, 18'h00123, 1'b0);
    push(c_ACT, 2'd1, 1'b0, 2'd1, 2'd2, 18'h00123, 1'b0);
    tick;
    check_val("rerr_cs",   CS_n, 2'b11);
    check_val("rerr_flag", rank_err, 1'b1);
    check_val("rerr_iss",  cmd_issued, 1'b0);
    check_val("rerr_pins", pins(), 4'b0000);
    tick;
    check_val("rnext_cs",   CS_n, 2'b01);
    check_val("rnext_iss",  cmd_issued, 1'b1);
    check_val("rnext_flag", rank_err, 1'b0);
    check_val("rnext_addr", ADDR, 14'h0123);
    tick; tick;

    // 2T RDs pushed every cycle until the FIFO fills
    mode_2t = 1'b1;
    par_en  = 1'b1;
    for (int c = 0; c < 7; c++) begin
      set_req(c_RD, 2'd0, 1'b0, 2'd0, 2'd0, 18'h003F0, 1'b1);
      tick;
      check_val($sformatf("rd2t_cnt_%0d", c), fifo_count, exp_cnt_2t[c]);
      if (c == 2 || c == 5) begin
        check_val($sformatf("rd2t_setup_cs_%0d", c),   CS_n, 2'b11);
        check_val($sformatf("rd2t_setup_pins_%0d", c), pins(), 4'b1101);
        check_val($sformatf("rd2t_setup_addr_%0d", c), ADDR, 14'h17F0);
        check_val($sformatf("rd2t_setup_iss_%0d", c),  cmd_issued, 1'b0);
        check_val($sformatf("rd2t_setup_par_%0d", c),  PARITY, 1'b1);
      end
      if (c == 3 || c == 6) begin
        check_val($sformatf("rd2t_assert_cs_%0d", c),  CS_n, 2'b10);
        check_val($sformatf("rd2t_assert_iss_%0d", c), cmd_issued, 1'b1);
      end
      if (c == 4) begin
        check_val("rd2t_des_cs",   CS_n, 2'b11);
        check_val("rd2t_des_addr", ADDR, 14'h0);
        check_val("rd2t_des_par",  PARITY, 1'b0);
      end
      if (c >= 5) check_val($sformatf("rd2t_full_ready_%0d", c), req_ready, 1'b0);
    end
    req_valid = 1'b0;
    tick;
    check_val("rd2t_pop_cnt", fifo_count, 3'd3);
    check_val("rd2t_idle_cs", CS_n, 2'b11);
    tick;
    check_val("rd2t_setup2_addr", ADDR, 14'h17F0);
    check_val("rd2t_setup2_cnt",  fifo_count, 3'd3);

    // Asynchronous reset in SETUP with three entries queued
    #2;
    RST = 1'b1;
    #1;
    check_val("arst_cs",    CS_n, 2'b11);
    check_val("arst_pins",  pins(), 4'hF);
    check_val("arst_addr",  ADDR, 14'h0);
    check_val("arst_cnt",   fifo_count, 3'd0);
    check_val("arst_ready", req_ready, 1'b1);
    tick;
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      check_val($sformatf("post_rst_iss_%0d", c), cmd_issued, 1'b0);
      check_val($sformatf("post_rst_cs_%0d", c),  CS_n, 2'b11);
    end
    check_val("post_rst_cnt", fifo_count, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
